cache_tag_match: RTL and testbench
==================================

// Module: cache_tag_match
// PURPOSE
//  Lookup stage of the 4-way set-associative cache, directly upstream of the way data mux.
//  - Compares the request tag against the 4 way entries read from the set array.
//  - Registers a one-hot way select (hit way), hit/miss status and a one-hot victim select.
//  - Victim choice comes from a per-set tree pseudo-LRU held inside this block.
//  - o_way_sel drives the downstream 4:1 line mux select directly.
// PARAMETERS
//  LINE_SIZE_BYTES  4   data bytes per line; DATA_BITS = LINE_SIZE_BYTES*8
//  TAG_BITS         18  tag width
//  INDEX_BITS       6   set index width; SETS = 2**INDEX_BITS
//  VALID_BITS       1   valid field width
//  LRU_BITS         1   per-entry LRU field width; carried in the entry, ignored here
//  DIRTY_BITS       1   dirty field width
//  WAYS             4   fixed; localparam, not overridable
//  Entry layout, LSB up: data[DATA_BITS], tag, dirty, lru, valid (MSB). ENTRY_BITS = sum.
// PORTS
//  i_clk           in   1               clock
//  i_rst_n         in   1               async active-low reset
//  i_req_valid     in   1               lookup request valid
//  o_req_ready     out  1               stage can accept a request
//  i_req_tag       in   TAG_BITS        request tag
//  i_req_index     in   INDEX_BITS      request set index
//  i_way_entry     in   WAYS*ENTRY_BITS entries of set i_req_index; way w at [w*ENTRY_BITS +: ENTRY_BITS]
//  o_rsp_valid     out  1               response valid
//  i_rsp_ready     in   1               downstream accepts the response
//  o_hit           out  1               request tag matched a valid way
//  o_way_sel       out  WAYS            one-hot hit way; 0 on miss
//  o_victim_sel    out  WAYS            one-hot replacement way; valid only on miss
//  o_victim_dirty  out  1               dirty bit of the victim way
//  o_multi_hit     out  1               more than one way matched (error flag)
//  o_index         out  INDEX_BITS      registered index
// BEHAVIOUR
//  - Reset: every output 0 except o_req_ready = 1; all PLRU state 0.
//  - Handshake: o_req_ready = !o_rsp_valid | i_rsp_ready.
//  - Accept: i_req_valid & o_req_ready. The response registers one cycle after acceptance.
//  - o_rsp_valid is held, with all payload stable, until i_rsp_ready is sampled high.
//  - Back-to-back requests run at full throughput when i_rsp_ready stays high.
//  - Match in way w: valid bit set & tag equal.
//  - Multi-hit: o_multi_hit = 1 and o_way_sel picks the lowest matching way.
//  - Victim: the lowest-index invalid way if any exists; otherwise the PLRU victim.
//  - PLRU, 3 bits per set [b0 root, b1 ways0/1, b2 ways2/3]:
//    - Victim walk: b0=0 -> left (b1=0 ? way0 : way1); b0=1 -> right (b2=0 ? way2 : way3).
//    - Update: on the response handshake, touch way = hit ? o_way_sel : o_victim_sel.
//    - Touch sets the tree bits to point away from that way.
//  - Same-index hazard: if the accepted request's index equals a response index handshaking
//    in the same cycle, the victim uses the post-update PLRU value (bypass).
//  - Reset asserted mid-operation drops the pending response; no PLRU update occurs.
// CONFIGURATION
//  CACHE_TAG_MATCH_STATS_EN defined:
//    - adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0].
//    - each increments on a response handshake and saturates at 32'hFFFF_FFFF.
//    - both reset to 0.
//  Not defined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package cache_pkg:
//    - WAYS, PLRU_BITS = 3.
//    - entry field offset/width functions derived from the parameters.
//    - typedef for a way one-hot vector.
//  Sub-module plru_tree4: combinational victim walk plus next-state update for one 3-bit tree.
//  Top level holds the PLRU array, pipeline register, handshake logic and, when enabled,
//  the counters.
// TESTING
//  1. Reset, then a request where way2 is valid with a matching tag:
//     -> 1 cycle later o_rsp_valid=1, o_hit=1, o_way_sel=4'b0100.
//  2. Miss with all ways invalid -> o_hit=0, o_way_sel=0, o_victim_sel=4'b0001.
//  3. All ways valid, 4 consecutive misses to index 5 with PLRU at reset:
//     -> victims in order 4'b0001, 4'b0100, 4'b0010, 4'b1000.
//  4. Hold i_rsp_ready=0 for 3 cycles:
//     -> o_req_ready=0 and the response is stable; release -> one handshake, next request accepted.
//  5. Ways1 and 3 both match -> o_multi_hit=1, o_way_sel=4'b0010.
//  6. With STATS_EN: 3 hits and 2 misses -> o_hit_cnt=3, o_miss_cnt=2.
//     Forcing a counter to 32'hFFFF_FFFF and adding one more event leaves it at that value.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache lookup stage.
//   WAYS        fixed associativity (4)
//   PLRU_BITS   tree pseudo-LRU bits per set [b0 root, b1 ways0/1, b2 ways2/3]
//   way_oh_t    one-hot way vector
//   plru_t      per-set PLRU tree state
//   Entry layout, LSB up: data, tag, dirty, lru, valid (MSB); helpers below
//   return field offsets and widths from the configuration parameters.
package cache_pkg;

   localparam int unsigned WAYS      = 4;
   localparam int unsigned PLRU_BITS = 3;

   typedef logic [WAYS-1:0]      way_oh_t;
   typedef logic [PLRU_BITS-1:0] plru_t;

   function automatic int unsigned data_bits(input int unsigned line_bytes);
      return line_bytes * 8;
   endfunction

   function automatic int unsigned tag_lsb(input int unsigned line_bytes);
      return data_bits(line_bytes);
   endfunction

   function automatic int unsigned dirty_lsb(input int unsigned line_bytes,
                                             input int unsigned tag_w);
      return tag_lsb(line_bytes) + tag_w;
   endfunction

   function automatic int unsigned lru_lsb(input int unsigned line_bytes,
                                           input int unsigned tag_w,
                                           input int unsigned dirty_w);
      return dirty_lsb(line_bytes, tag_w) + dirty_w;
   endfunction

   function automatic int unsigned valid_lsb(input int unsigned line_bytes,
                                             input int unsigned tag_w,
                                             input int unsigned dirty_w,
                                             input int unsigned lru_w);
      return lru_lsb(line_bytes, tag_w, dirty_w) + lru_w;
   endfunction

   function automatic int unsigned entry_bits(input int unsigned line_bytes,
                                              input int unsigned tag_w,
                                              input int unsigned dirty_w,
                                              input int unsigned lru_w,
                                              input int unsigned valid_w);
      return valid_lsb(line_bytes, tag_w, dirty_w, lru_w) + valid_w;
   endfunction

endpackage

// File: rtl/plru_tree4.sv
// Combinational 4-way tree pseudo-LRU for one set.
//   cur_state   tree state of the set being touched
//   touch_way   one-hot way to mark most recently used
//   touch_en    apply the touch
//   req_state   tree state of the set being looked up
//   bypass      look up through the freshly updated state (same set touched now)
//   next_state  cur_state after the touch
//   victim      one-hot way the tree currently points at
module plru_tree4
   import cache_pkg::*;
(
   input  plru_t   cur_state,
   input  way_oh_t touch_way,
   input  logic    touch_en,
   input  plru_t   req_state,
   input  logic    bypass,
   output plru_t   next_state,
   output way_oh_t victim
);

   plru_t walk_state;

   // Touch: point every bit on the path away from the touched way.
   always_comb begin
      next_state = cur_state;
      if (touch_en) begin
         case (touch_way)
            4'b0001: begin next_state[0] = 1'b1; next_state[1] = 1'b1; end
            4'b0010: begin next_state[0] = 1'b1; next_state[1] = 1'b0; end
            4'b0100: begin next_state[0] = 1'b0; next_state[2] = 1'b1; end
            4'b1000: begin next_state[0] = 1'b0; next_state[2] = 1'b0; end
            default: next_state = cur_state;
         endcase
      end
   end

   // Victim walk: root picks a half, the half's bit picks the way.
   always_comb begin
      walk_state = bypass ? next_state : req_state;
      victim     = '0;
      if (!walk_state[0]) begin
         victim = walk_state[1] ? 4'b0010 : 4'b0001;
      end else begin
         victim = walk_state[2] ? 4'b1000 : 4'b0100;
      end
   end

endmodule

// File: rtl/cache_tag_match.sv
// Lookup stage of the 4-way set-associative cache: tag compare against the
// set's entries, registered hit-way / victim one-hots, per-set tree PLRU.
// Optional feature macro: CACHE_TAG_MATCH_STATS_EN adds saturating hit/miss
// counters (o_hit_cnt, o_miss_cnt).
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_valid / o_req_ready      request handshake
//   i_req_tag, i_req_index         lookup key
//   i_way_entry                    4 entries of the indexed set, way w at [w*ENTRY_BITS +: ENTRY_BITS]
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_hit, o_way_sel, o_multi_hit  hit status, one-hot hit way (lowest match)
//   o_victim_sel, o_victim_dirty   replacement way and its dirty bit
//   o_index                        registered set index
module cache_tag_match
   import cache_pkg::*;
#(
   parameter int unsigned LINE_SIZE_BYTES = 4,
   parameter int unsigned TAG_BITS        = 18,
   parameter int unsigned INDEX_BITS      = 6,
   parameter int unsigned VALID_BITS      = 1,
   parameter int unsigned LRU_BITS        = 1,
   parameter int unsigned DIRTY_BITS      = 1
)(
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic                                   i_req_valid,
   output logic                                   o_req_ready,
   input  logic [TAG_BITS-1:0]                    i_req_tag,
   input  logic [INDEX_BITS-1:0]                  i_req_index,
   input  logic [WAYS*entry_bits(LINE_SIZE_BYTES, TAG_BITS, DIRTY_BITS,
                                 LRU_BITS, VALID_BITS)-1:0] i_way_entry,
   output logic                                   o_rsp_valid,
   input  logic                                   i_rsp_ready,
   output logic                                   o_hit,
   output logic [WAYS-1:0]                        o_way_sel,
   output logic [WAYS-1:0]                        o_victim_sel,
   output logic                                   o_victim_dirty,
   output logic                                   o_multi_hit,
   output logic [INDEX_BITS-1:0]                  o_index
`ifdef CACHE_TAG_MATCH_STATS_EN
   ,
   output logic [31:0]                            o_hit_cnt,
   output logic [31:0]                            o_miss_cnt
`endif
);

   localparam int unsigned DATA_BITS  = data_bits(LINE_SIZE_BYTES);
   localparam int unsigned TAG_LSB    = tag_lsb(LINE_SIZE_BYTES);
   localparam int unsigned DIRTY_LSB  = dirty_lsb(LINE_SIZE_BYTES, TAG_BITS);
   localparam int unsigned LRU_LSB    = lru_lsb(LINE_SIZE_BYTES, TAG_BITS, DIRTY_BITS);
   localparam int unsigned VALID_LSB  = valid_lsb(LINE_SIZE_BYTES, TAG_BITS, DIRTY_BITS, LRU_BITS);
   localparam int unsigned ENTRY_BITS = entry_bits(LINE_SIZE_BYTES, TAG_BITS, DIRTY_BITS,
                                                   LRU_BITS, VALID_BITS);
   localparam int unsigned SETS       = 1 << INDEX_BITS;

   logic                  accept;
   logic                  rsp_hs;
   logic [ENTRY_BITS-1:0] entry;
   way_oh_t               way_valid;
   way_oh_t               way_dirty;
   way_oh_t               match;
   way_oh_t               hit_way_c;
   way_oh_t               free_way_c;
   way_oh_t               plru_victim;
   way_oh_t               victim_c;
   way_oh_t               touch_way;
   logic                  hit_found;
   logic                  free_found;
   logic                  multi_c;
   logic                  victim_dirty_c;
   logic                  bypass;
   logic                  unused_fields;
   plru_t                 plru_q [SETS];
   plru_t                 plru_next;

   assign o_req_ready = !o_rsp_valid || i_rsp_ready;
   assign accept      = i_req_valid && o_req_ready;
   assign rsp_hs      = o_rsp_valid && i_rsp_ready;

   // Per-way field decode and tag compare; data and lru fields pass through untouched.
   always_comb begin
      entry         = '0;
      way_valid     = '0;
      way_dirty     = '0;
      match         = '0;
      unused_fields = 1'b0;
      for (int w = 0; w < int'(WAYS); w++) begin
         entry         = i_way_entry[w*ENTRY_BITS +: ENTRY_BITS];
         way_valid[w]  = |entry[VALID_LSB +: VALID_BITS];
         way_dirty[w]  = |entry[DIRTY_LSB +: DIRTY_BITS];
         match[w]      = way_valid[w] && (entry[TAG_LSB +: TAG_BITS] == i_req_tag);
         unused_fields = unused_fields ^ (^entry[DATA_BITS-1:0]) ^ (^entry[LRU_LSB +: LRU_BITS]);
      end
   end

   // Lowest matching way and lowest invalid way.
   always_comb begin
      hit_way_c  = '0;
      free_way_c = '0;
      hit_found  = 1'b0;
      free_found = 1'b0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (match[w] && !hit_found) begin
            hit_way_c[w] = 1'b1;
            hit_found    = 1'b1;
         end
         if (!way_valid[w] && !free_found) begin
            free_way_c[w] = 1'b1;
            free_found    = 1'b1;
         end
      end
   end

   // More than one bit set in match.
   assign multi_c        = |(match & (match - way_oh_t'(1)));
   assign victim_c       = free_found ? free_way_c : plru_victim;
   assign victim_dirty_c = |(victim_c & way_dirty);

   // Update uses the handshaking response; lookup forwards it when the set collides.
   assign touch_way = o_hit ? o_way_sel : o_victim_sel;
   assign bypass    = rsp_hs && (i_req_index == o_index);

   plru_tree4 u_plru (
      .cur_state  (plru_q[o_index]),
      .touch_way  (touch_way),
      .touch_en   (rsp_hs),
      .req_state  (plru_q[i_req_index]),
      .bypass     (bypass),
      .next_state (plru_next),
      .victim     (plru_victim)
   );

   // PLRU state array.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < int'(SETS); s++) begin
            plru_q[s] <= '0;
         end
      end else if (rsp_hs) begin
         plru_q[o_index] <= plru_next;
      end
   end

   // Response register: loads on accept, holds until the downstream takes it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rsp_valid    <= 1'b0;
         o_hit          <= 1'b0;
         o_way_sel      <= '0;
         o_victim_sel   <= '0;
         o_victim_dirty <= 1'b0;
         o_multi_hit    <= 1'b0;
         o_index        <= '0;
      end else if (accept) begin
         o_rsp_valid    <= 1'b1;
         o_hit          <= hit_found;
         o_way_sel      <= hit_way_c;
         o_victim_sel   <= victim_c;
         o_victim_dirty <= victim_dirty_c;
         o_multi_hit    <= multi_c;
         o_index        <= i_req_index;
      end else if (rsp_hs) begin
         o_rsp_valid    <= 1'b0;
      end
   end

`ifdef CACHE_TAG_MATCH_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating hit/miss counters, counted at response handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (rsp_hs) begin
         if (o_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (!o_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign o_hit_cnt  = hit_cnt_q;
   assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_tag_match.sv
// Directed self-checking bench for cache_tag_match (default parameters).
// Build with CACHE_TAG_MATCH_STATS_EN to also exercise the counters.
module tb_cache_tag_match;
   import cache_pkg::*;

   localparam int unsigned EB = 53;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [17:0]   req_tag;
   logic [5:0]    req_index;
   logic [4*EB-1:0] way_entry;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          hit;
   logic [3:0]    way_sel;
   logic [3:0]    victim_sel;
   logic          victim_dirty;
   logic          multi_hit;
   logic [5:0]    index;
`ifdef CACHE_TAG_MATCH_STATS_EN
   logic [31:0]   hit_cnt;
   logic [31:0]   miss_cnt;
`endif

   int passed = 0;
   int total  = 0;

   cache_tag_match dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_tag      (req_tag),
      .i_req_index    (req_index),
      .i_way_entry    (way_entry),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_hit          (hit),
      .o_way_sel      (way_sel),
      .o_victim_sel   (victim_sel),
      .o_victim_dirty (victim_dirty),
      .o_multi_hit    (multi_hit),
      .o_index        (index)
`ifdef CACHE_TAG_MATCH_STATS_EN
      ,
      .o_hit_cnt      (hit_cnt),
      .o_miss_cnt     (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entry: {valid, lru, dirty, tag, data}
   function automatic logic [EB-1:0] mk(input logic v, input logic d, input logic [17:0] tag);
      return {v, 1'b0, d, tag, 32'hDEAD_BEEF};
   endfunction

   task automatic set_ways(input logic [EB-1:0] e0, input logic [EB-1:0] e1,
                           input logic [EB-1:0] e2, input logic [EB-1:0] e3);
      way_entry = {e3, e2, e1, e0};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; req_tag = '0; req_index = '0;
      set_ways('0, '0, '0, '0);
      step(); step();
      if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++; total++;
      if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++; total++;
      if ({hit, multi_hit, victim_dirty} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {hit, multi_hit, victim_dirty}); else passed++; total++;
      if ({way_sel, victim_sel, index} !== 14'h0) $display("FAIL reset_payload got %h exp 0", {way_sel, victim_sel, index}); else passed++; total++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_hit();
      req_tag = 18'h1234; req_index = 6'd3;
      set_ways(mk(1, 0, 18'h0001), mk(1, 0, 18'h0002), mk(1, 0, 18'h1234), mk(1, 0, 18'h0003));
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      if (rsp_valid !== 1'b1) $display("FAIL hit_rsp_valid got %b exp 1", rsp_valid); else passed++; total++;
      if (hit !== 1'b1) $display("FAIL hit_flag got %b exp 1", hit); else passed++; total++;
      if (way_sel !== 4'b0100) $display("FAIL hit_way_sel got %b exp 0100", way_sel); else passed++; total++;
      if (multi_hit !== 1'b0) $display("FAIL hit_multi got %b exp 0", multi_hit); else passed++; total++;
      if (index !== 6'd3) $display("FAIL hit_index got %0d exp 3", index); else passed++; total++;
      step();
      if (rsp_valid !== 1'b0) $display("FAIL hit_drain got %b exp 0", rsp_valid); else passed++; total++;
   endtask

   task automatic test_miss_invalid();
      req_tag = 18'h0AAA; req_index = 6'd7;
      set_ways(mk(0, 1, 18'h0AAA), mk(0, 0, 18'h0AAA), mk(0, 0, 18'h0), mk(0, 0, 18'h0));
      req_valid = 1'b1;
      step();
      if (hit !== 1'b0) $display("FAIL miss_hit got %b exp 0", hit); else passed++; total++;
      if (way_sel !== 4'b0000) $display("FAIL miss_way_sel got %b exp 0000", way_sel); else passed++; total++;
      if (victim_sel !== 4'b0001) $display("FAIL miss_victim got %b exp 0001", victim_sel); else passed++; total++;
      if (victim_dirty !== 1'b1) $display("FAIL miss_victim_dirty got %b exp 1", victim_dirty); else passed++; total++;
      // Lowest invalid way wins over the PLRU choice.
      set_ways(mk(1, 0, 18'h1), mk(1, 0, 18'h2), mk(0, 1, 18'h3), mk(0, 0, 18'h4));
      step();
      req_valid = 1'b0;
      if (victim_sel !== 4'b0100) $display("FAIL miss_lowest_invalid got %b exp 0100", victim_sel); else passed++; total++;
      if (victim_dirty !== 1'b1) $display("FAIL miss_lowest_invalid_dirty got %b exp 1", victim_dirty); else passed++; total++;
      step();
   endtask

   task automatic test_plru_sequence();
      logic [3:0] exp_v [5];
      logic       exp_d [5];
      exp_v[0] = 4'b0001; exp_v[1] = 4'b0100; exp_v[2] = 4'b0010; exp_v[3] = 4'b1000; exp_v[4] = 4'b0001;
      exp_d[0] = 1'b0;    exp_d[1] = 1'b1;    exp_d[2] = 1'b0;    exp_d[3] = 1'b0;    exp_d[4] = 1'b0;
      req_tag = 18'h3FFFF; req_index = 6'd5;
      set_ways(mk(1, 0, 18'h10), mk(1, 0, 18'h11), mk(1, 1, 18'h12), mk(1, 0, 18'h13));
      rsp_ready = 1'b1; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (victim_sel !== exp_v[i]) $display("FAIL plru_victim_%0d got %b exp %b", i, victim_sel, exp_v[i]); else passed++; total++;
         if (victim_dirty !== exp_d[i]) $display("FAIL plru_dirty_%0d got %b exp %b", i, victim_dirty, exp_d[i]); else passed++; total++;
      end
      req_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back_stall();
      req_tag = 18'h00ABC; req_index = 6'd9;
      set_ways(mk(1, 0, 18'h00ABC), mk(0, 0, 18'h0), mk(0, 0, 18'h0), mk(0, 0, 18'h0));
      rsp_ready = 1'b0; req_valid = 1'b1;
      step();
      // Second request waits; its inputs differ from the held response.
      req_tag = 18'h00DEF; req_index = 6'd10;
      set_ways('0, '0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         if (req_ready !== 1'b0) $display("FAIL stall_req_ready_%0d got %b exp 0", i, req_ready); else passed++; total++;
         if ({rsp_valid, hit, way_sel, index} !== {1'b1, 1'b1, 4'b0001, 6'd9})
            $display("FAIL stall_hold_%0d got %h exp %h", i, {rsp_valid, hit, way_sel, index}, {1'b1, 1'b1, 4'b0001, 6'd9});
         else passed++;
         total++;
         step();
      end
      rsp_ready = 1'b1;
      #1;
      if (req_ready !== 1'b1) $display("FAIL stall_release_ready got %b exp 1", req_ready); else passed++; total++;
      step();
      req_valid = 1'b0;
      if ({rsp_valid, hit, index, victim_sel} !== {1'b1, 1'b0, 6'd10, 4'b0001})
         $display("FAIL stall_next_req got %h exp %h", {rsp_valid, hit, index, victim_sel}, {1'b1, 1'b0, 6'd10, 4'b0001});
      else passed++;
      total++;
      step();
      if (rsp_valid !== 1'b0) $display("FAIL stall_drain got %b exp 0", rsp_valid); else passed++; total++;
   endtask

   task automatic test_multi_hit();
      req_tag = 18'h2_5555; req_index = 6'd11;
      set_ways(mk(0, 0, 18'h2_5555), mk(1, 0, 18'h2_5555), mk(1, 0, 18'h0_0001), mk(1, 0, 18'h2_5555));
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      if (multi_hit !== 1'b1) $display("FAIL multi_flag got %b exp 1", multi_hit); else passed++; total++;
      if (way_sel !== 4'b0010) $display("FAIL multi_way_sel got %b exp 0010", way_sel); else passed++; total++;
      if (hit !== 1'b1) $display("FAIL multi_hit_flag got %b exp 1", hit); else passed++; total++;
      step();
   endtask

   task automatic test_reset_mid();
      req_tag = 18'h1; req_index = 6'd5;
      set_ways(mk(1, 0, 18'h7), mk(1, 0, 18'h8), mk(1, 0, 18'h9), mk(1, 0, 18'hA));
      rsp_ready = 1'b0; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      if (rsp_valid !== 1'b1) $display("FAIL rstmid_pending got %b exp 1", rsp_valid); else passed++; total++;
      rst_n = 1'b0;
      #1;
      if (rsp_valid !== 1'b0) $display("FAIL rstmid_dropped got %b exp 0", rsp_valid); else passed++; total++;
      if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", req_ready); else passed++; total++;
      step();
      rst_n = 1'b1; rsp_ready = 1'b1;
      step();
      // PLRU of set 5 must be back at reset: first all-valid miss picks way0.
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      if (victim_sel !== 4'b0001) $display("FAIL rstmid_plru got %b exp 0001", victim_sel); else passed++; total++;
      step();
   endtask

`ifdef CACHE_TAG_MATCH_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      rsp_ready = 1'b1; req_index = 6'd20;
      set_ways(mk(1, 0, 18'h100), mk(1, 0, 18'h101), mk(1, 0, 18'h102), mk(1, 0, 18'h103));
      req_valid = 1'b1;
      req_tag = 18'h100; step();
      req_tag = 18'h102; step();
      req_tag = 18'h103; step();
      req_tag = 18'h3FF; step();
      req_tag = 18'h3FE; step();
      req_valid = 1'b0;
      step();
      if (hit_cnt !== 32'd3) $display("FAIL stats_hits got %0d exp 3", hit_cnt); else passed++; total++;
      if (miss_cnt !== 32'd2) $display("FAIL stats_misses got %0d exp 2", miss_cnt); else passed++; total++;
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.hit_cnt_q;
      req_tag = 18'h101; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      if (hit_cnt !== 32'hFFFF_FFFF) $display("FAIL stats_saturate got %h exp ffffffff", hit_cnt); else passed++; total++;
      if (miss_cnt !== 32'd2) $display("FAIL stats_miss_hold got %0d exp 2", miss_cnt); else passed++; total++;
   endtask
`endif

   initial begin
      test_reset();
      test_hit();
      test_miss_invalid();
      test_plru_sequence();
      test_back_to_back_stall();
      test_multi_hit();
      test_reset_mid();
`ifdef CACHE_TAG_MATCH_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
